// File: rtl/multi_player_action_if.sv
// Player inputs, external cell-write port and grid/held/grant outputs of multi_player_action.
interface multi_player_action_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int ROWS        = 8,
    parameter int COLS        = 13,
    parameter int OBJ_W       = 4,
    parameter int CHOP_FRAMES = 60
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NP_W  = $clog2(NUM_PLAYERS + 1);
    localparam int CNT_W = $clog2(CHOP_FRAMES + 1);

    logic                                    enable;
    logic [NP_W-1:0]                         num_players;
    logic [NUM_PLAYERS-1:0]                  carry;
    logic [NUM_PLAYERS-1:0]                  chop;
    logic [NUM_PLAYERS-1:0][1:0]             player_dir;
    logic [NUM_PLAYERS-1:0][8:0]             player_x;
    logic [NUM_PLAYERS-1:0][8:0]             player_y;
    logic                                    ext_we;
    logic [ROW_W-1:0]                        ext_row;
    logic [COL_W-1:0]                        ext_col;
    logic [OBJ_W-1:0]                        ext_obj;
    logic [ROWS-1:0][COLS-1:0][OBJ_W-1:0]    object_grid;
    logic [NUM_PLAYERS-1:0][OBJ_W-1:0]       held_obj;
    logic [NUM_PLAYERS-1:0][CNT_W-1:0]       chop_progress;
    logic [NUM_PLAYERS-1:0]                  grant;

    modport master (
        output enable, num_players, carry, chop, player_dir, player_x, player_y,
               ext_we, ext_row, ext_col, ext_obj,
        input  object_grid, held_obj, chop_progress, grant
    );

    modport slave (
        input  enable, num_players, carry, chop, player_dir, player_x, player_y,
               ext_we, ext_row, ext_col, ext_obj,
        output object_grid, held_obj, chop_progress, grant
    );
endinterface

// File: rtl/multi_player_action.sv
// Frame-clocked arbiter of carry/chop actions from several players against one shared object grid.
// Owns the grid and per-player held objects; the external write port always wins a frame.
module multi_player_action #(
    parameter int NUM_PLAYERS = 2,
    parameter int ROWS        = 8,
    parameter int COLS        = 13,
    parameter int OBJ_W       = 4,
    parameter int TILE_SHIFT  = 5,
    parameter int CHOP_FRAMES = 60
) (
    input  logic                 vsync,
    input  logic                 reset,
    multi_player_action_if.slave bus
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(CHOP_FRAMES + 1);
    localparam int PTR_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [OBJ_W-1:0] CHOP_FLAG = OBJ_W'(1) << (OBJ_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CHOP_FRAMES);

    typedef logic [ROWS-1:0][COLS-1:0][OBJ_W-1:0] grid_t;

    function automatic logic is_raw(input logic [OBJ_W-1:0] obj);
        return (obj != {OBJ_W{1'b0}}) && !obj[OBJ_W-1];
    endfunction

    grid_t                              grid_r, grid_s;
    logic [NUM_PLAYERS-1:0][OBJ_W-1:0]  held_r, held_s;
    logic [NUM_PLAYERS-1:0][CNT_W-1:0]  cnt_r, cnt_s;
    logic [NUM_PLAYERS-1:0]             pend_carry_r, pend_carry_s;
    logic [NUM_PLAYERS-1:0]             pend_chop_r, pend_chop_s;
    logic [NUM_PLAYERS-1:0]             carry_prev_r;
    logic [NUM_PLAYERS-1:0]             grant_r, grant_s;
    logic [NUM_PLAYERS-1:0][ROW_W-1:0]  carry_row_r, carry_row_s, chop_row_r, chop_row_s;
    logic [NUM_PLAYERS-1:0][COL_W-1:0]  carry_col_r, carry_col_s, chop_col_r, chop_col_s;
    logic [PTR_W-1:0]                   rr_ptr_r, rr_ptr_s;

    logic [NUM_PLAYERS-1:0][9:0]        row_full_s, col_full_s;
    logic [NUM_PLAYERS-1:0][ROW_W-1:0]  tgt_row_s;
    logic [NUM_PLAYERS-1:0][COL_W-1:0]  tgt_col_s;
    logic [NUM_PLAYERS-1:0][OBJ_W-1:0]  tgt_cell_s;
    logic [NUM_PLAYERS-1:0]             tgt_ok_s, active_s, req_s, chop_ok_s, carry_rise_s;
    logic [PTR_W-1:0]                   cand_s, gidx_s;
    logic                               found_s;
    logic [OBJ_W-1:0]                   gcell_s;

    // Facing tile per player, one bit wider than needed so stepping off either edge reads out of range.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            row_full_s[p] = 10'(bus.player_y[p] >> TILE_SHIFT);
            col_full_s[p] = 10'(bus.player_x[p] >> TILE_SHIFT);
            case (bus.player_dir[p])
                2'd0:    col_full_s[p] = col_full_s[p] - 10'd1;
                2'd1:    col_full_s[p] = col_full_s[p] + 10'd1;
                2'd2:    row_full_s[p] = row_full_s[p] - 10'd1;
                2'd3:    row_full_s[p] = row_full_s[p] + 10'd1;
                default: row_full_s[p] = row_full_s[p];
            endcase
            tgt_ok_s[p]     = (row_full_s[p] < 10'(ROWS)) && (col_full_s[p] < 10'(COLS));
            tgt_row_s[p]    = row_full_s[p][ROW_W-1:0];
            tgt_col_s[p]    = col_full_s[p][COL_W-1:0];
            tgt_cell_s[p]   = grid_r[tgt_row_s[p]][tgt_col_s[p]];
            active_s[p]     = p < int'(bus.num_players);
            carry_rise_s[p] = bus.carry[p] && !carry_prev_r[p];
            req_s[p]        = bus.enable && active_s[p] && (pend_carry_r[p] || pend_chop_r[p]);
            chop_ok_s[p]    = bus.enable && active_s[p] && bus.chop[p] &&
                              (held_r[p] == {OBJ_W{1'b0}}) && tgt_ok_s[p] && is_raw(tgt_cell_s[p]);
        end
    end

    // Next-state: pending/counter bookkeeping, then either the external write or one granted action.
    always_comb begin
        grid_s       = grid_r;
        held_s       = held_r;
        cnt_s        = cnt_r;
        pend_carry_s = pend_carry_r;
        pend_chop_s  = pend_chop_r;
        carry_row_s  = carry_row_r;
        carry_col_s  = carry_col_r;
        chop_row_s   = chop_row_r;
        chop_col_s   = chop_col_r;
        grant_s      = {NUM_PLAYERS{1'b0}};
        rr_ptr_s     = rr_ptr_r;
        cand_s       = {PTR_W{1'b0}};
        gidx_s       = {PTR_W{1'b0}};
        found_s      = 1'b0;
        gcell_s      = {OBJ_W{1'b0}};

        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (bus.enable && active_s[p]) begin
                if (carry_rise_s[p] && tgt_ok_s[p] && !pend_carry_r[p]) begin
                    pend_carry_s[p] = 1'b1;
                    carry_row_s[p]  = tgt_row_s[p];
                    carry_col_s[p]  = tgt_col_s[p];
                end else begin
                    pend_carry_s[p] = pend_carry_r[p];
                end
                if (pend_chop_r[p]) begin
                    cnt_s[p] = cnt_r[p];
                end else if (chop_ok_s[p]) begin
                    if ((tgt_row_s[p] == chop_row_r[p]) && (tgt_col_s[p] == chop_col_r[p])) begin
                        cnt_s[p] = cnt_r[p] + CNT_W'(1);
                    end else begin
                        cnt_s[p]      = CNT_W'(1);
                        chop_row_s[p] = tgt_row_s[p];
                        chop_col_s[p] = tgt_col_s[p];
                    end
                    pend_chop_s[p] = (cnt_s[p] == CNT_MAX);
                end else begin
                    cnt_s[p] = {CNT_W{1'b0}};
                end
            end else begin
                pend_carry_s[p] = 1'b0;
                pend_chop_s[p]  = 1'b0;
                cnt_s[p]        = {CNT_W{1'b0}};
            end
        end

        if (bus.ext_we) begin
            if ((int'(bus.ext_row) < ROWS) && (int'(bus.ext_col) < COLS)) begin
                grid_s[bus.ext_row][bus.ext_col] = bus.ext_obj;
            end else begin
                grid_s = grid_r;
            end
        end else begin
            for (int k = 0; k < NUM_PLAYERS; k++) begin
                cand_s = PTR_W'((int'(rr_ptr_r) + k) % NUM_PLAYERS);
                if (!found_s && req_s[cand_s]) begin
                    found_s = 1'b1;
                    gidx_s  = cand_s;
                end else begin
                    found_s = found_s;
                end
            end
            if (found_s) begin
                grant_s[gidx_s] = 1'b1;
                rr_ptr_s        = PTR_W'((int'(gidx_s) + 1) % NUM_PLAYERS);
                // Chop wins over carry within a player; a pending carry stays queued behind it.
                if (pend_chop_r[gidx_s]) begin
                    gcell_s = grid_r[chop_row_r[gidx_s]][chop_col_r[gidx_s]];
                    if (is_raw(gcell_s)) begin
                        grid_s[chop_row_r[gidx_s]][chop_col_r[gidx_s]] = gcell_s | CHOP_FLAG;
                    end else begin
                        grid_s = grid_r;
                    end
                    pend_chop_s[gidx_s] = 1'b0;
                    cnt_s[gidx_s]       = {CNT_W{1'b0}};
                end else begin
                    gcell_s = grid_r[carry_row_r[gidx_s]][carry_col_r[gidx_s]];
                    if ((held_r[gidx_s] == {OBJ_W{1'b0}}) && (gcell_s != {OBJ_W{1'b0}})) begin
                        held_s[gidx_s] = gcell_s;
                        grid_s[carry_row_r[gidx_s]][carry_col_r[gidx_s]] = {OBJ_W{1'b0}};
                    end else if ((held_r[gidx_s] != {OBJ_W{1'b0}}) && (gcell_s == {OBJ_W{1'b0}})) begin
                        grid_s[carry_row_r[gidx_s]][carry_col_r[gidx_s]] = held_r[gidx_s];
                        held_s[gidx_s] = {OBJ_W{1'b0}};
                    end else begin
                        held_s = held_r;
                    end
                    pend_carry_s[gidx_s] = 1'b0;
                end
            end else begin
                rr_ptr_s = rr_ptr_r;
            end
        end
    end

    // Frame-rate state update; reset drops everything at once, including any pending action.
    always_ff @(posedge vsync or negedge reset) begin
        if (!reset) begin
            grid_r       <= '0;
            held_r       <= '0;
            cnt_r        <= '0;
            pend_carry_r <= '0;
            pend_chop_r  <= '0;
            carry_prev_r <= '0;
            grant_r      <= '0;
            carry_row_r  <= '0;
            carry_col_r  <= '0;
            chop_row_r   <= '0;
            chop_col_r   <= '0;
            rr_ptr_r     <= '0;
        end else begin
            grid_r       <= grid_s;
            held_r       <= held_s;
            cnt_r        <= cnt_s;
            pend_carry_r <= pend_carry_s;
            pend_chop_r  <= pend_chop_s;
            carry_prev_r <= bus.carry;
            grant_r      <= grant_s;
            carry_row_r  <= carry_row_s;
            carry_col_r  <= carry_col_s;
            chop_row_r   <= chop_row_s;
            chop_col_r   <= chop_col_s;
            rr_ptr_r     <= rr_ptr_s;
        end
    end

    assign bus.object_grid   = grid_r;
    assign bus.held_obj      = held_r;
    assign bus.chop_progress = cnt_r;
    assign bus.grant         = grant_r;
endmodule

// File: tb/tb_multi_player_action.sv
// Directed bench for multi_player_action: an integer-level model checked every frame, plus literal spot checks.
module tb_multi_player_action;
    localparam int NP = 2, ROWS = 8, COLS = 13, OBJ_W = 4, TS = 5, CF = 4;

    logic vsync, reset;

    multi_player_action_if #(.NUM_PLAYERS(NP), .ROWS(ROWS), .COLS(COLS), .OBJ_W(OBJ_W),
                             .CHOP_FRAMES(CF)) bus ();

    multi_player_action #(.NUM_PLAYERS(NP), .ROWS(ROWS), .COLS(COLS), .OBJ_W(OBJ_W),
                          .TILE_SHIFT(TS), .CHOP_FRAMES(CF)) dut (
        .vsync(vsync), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    int m_grid [ROWS][COLS];
    int m_held [NP], m_cnt [NP], m_ctr [NP], m_ctc [NP], m_ktr [NP], m_ktc [NP];
    bit m_pc [NP], m_pk [NP], m_prev [NP];
    int m_rr, m_win;

    initial begin
        vsync = 1'b0;
        forever #5 vsync = ~vsync;
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_raw(input int v);
        return v > 0 && v < (1 << (OBJ_W - 1));
    endfunction

    function automatic bit target(input int p, output int r, output int c);
        r = int'(bus.player_y[p]) / (1 << TS);
        c = int'(bus.player_x[p]) / (1 << TS);
        case (bus.player_dir[p])
            2'd0:    c = c - 1;
            2'd1:    c = c + 1;
            2'd2:    r = r - 1;
            default: r = r + 1;
        endcase
        return r >= 0 && r < ROWS && c >= 0 && c < COLS;
    endfunction

    task automatic model_clear();
        foreach (m_grid[r, c]) m_grid[r][c] = 0;
        for (int p = 0; p < NP; p++) begin
            m_held[p] = 0; m_cnt[p] = 0; m_ctr[p] = 0; m_ctc[p] = 0;
            m_ktr[p] = 0; m_ktc[p] = 0; m_pc[p] = 0; m_pk[p] = 0; m_prev[p] = 0;
        end
        m_rr = 0;
        m_win = -1;
    endtask

    task automatic model_step();
        int w, r, c, v;
        bit ok, act;
        int n_cnt [NP];
        bit n_pc [NP], n_pk [NP];
        w = -1;
        if (!bus.ext_we) begin
            for (int k = 0; k < NP; k++) begin
                int i;
                i = (m_rr + k) % NP;
                if (w < 0 && bus.enable && i < int'(bus.num_players) && (m_pc[i] || m_pk[i])) w = i;
            end
        end
        for (int p = 0; p < NP; p++) begin
            ok = target(p, r, c);
            act = bus.enable && (p < int'(bus.num_players));
            n_pc[p] = m_pc[p]; n_pk[p] = m_pk[p]; n_cnt[p] = m_cnt[p];
            if (!act) begin
                n_pc[p] = 0; n_pk[p] = 0; n_cnt[p] = 0;
            end else begin
                if (bus.carry[p] && !m_prev[p] && ok && !m_pc[p]) begin
                    n_pc[p] = 1; m_ctr[p] = r; m_ctc[p] = c;
                end
                if (!m_pk[p]) begin
                    if (bus.chop[p] && m_held[p] == 0 && ok && is_raw(m_grid[r][c])) begin
                        if (m_cnt[p] > 0 && r == m_ktr[p] && c == m_ktc[p]) n_cnt[p] = m_cnt[p] + 1;
                        else begin n_cnt[p] = 1; m_ktr[p] = r; m_ktc[p] = c; end
                        if (n_cnt[p] == CF) n_pk[p] = 1;
                    end else n_cnt[p] = 0;
                end
            end
            m_prev[p] = bus.carry[p];
        end
        if (w >= 0) begin
            if (m_pk[w]) begin
                v = m_grid[m_ktr[w]][m_ktc[w]];
                if (is_raw(v)) m_grid[m_ktr[w]][m_ktc[w]] = v + (1 << (OBJ_W - 1));
                n_pk[w] = 0; n_cnt[w] = 0;
            end else begin
                r = m_ctr[w]; c = m_ctc[w];
                if (m_held[w] == 0 && m_grid[r][c] != 0) begin
                    m_held[w] = m_grid[r][c]; m_grid[r][c] = 0;
                end else if (m_held[w] != 0 && m_grid[r][c] == 0) begin
                    m_grid[r][c] = m_held[w]; m_held[w] = 0;
                end
                n_pc[w] = 0;
            end
            m_rr = (w + 1) % NP;
        end
        if (bus.ext_we && int'(bus.ext_row) < ROWS && int'(bus.ext_col) < COLS)
            m_grid[bus.ext_row][bus.ext_col] = int'(bus.ext_obj);
        for (int p = 0; p < NP; p++) begin
            m_pc[p] = n_pc[p]; m_pk[p] = n_pk[p]; m_cnt[p] = n_cnt[p];
        end
        m_win = w;
    endtask

    task automatic compare_all();
        logic [ROWS-1:0][COLS-1:0][OBJ_W-1:0] eg;
        logic [NP-1:0][OBJ_W-1:0] eh;
        logic [NP-1:0][2:0] ec;
        logic [NP-1:0] egr;
        foreach (m_grid[r, c]) eg[r][c] = OBJ_W'(m_grid[r][c]);
        egr = '0;
        for (int p = 0; p < NP; p++) begin
            eh[p] = OBJ_W'(m_held[p]);
            ec[p] = 3'(m_cnt[p]);
            if (m_win == p) egr[p] = 1'b1;
        end
        chk("model grid", 512'(bus.object_grid), 512'(eg));
        chk("model held", 512'(bus.held_obj), 512'(eh));
        chk("model progress", 512'(bus.chop_progress), 512'(ec));
        chk("model grant", 512'(bus.grant), 512'(egr));
    endtask

    // Compare process: advance the model on each frame edge (or reset) and check all outputs.
    initial begin
        model_clear();
        forever begin
            @(posedge vsync or negedge reset);
            if (!reset) model_clear();
            else model_step();
            #1;
            compare_all();
        end
    end

    task automatic tick();
        @(negedge vsync);
    endtask

    task automatic ext_write(input int r, input int c, input int o);
        bus.ext_we = 1'b1; bus.ext_row = 3'(r); bus.ext_col = 4'(c); bus.ext_obj = 4'(o);
        tick();
        bus.ext_we = 1'b0;
    endtask

    task automatic place(input int p, input int x, input int y, input int d);
        bus.player_x[p] = 9'(x); bus.player_y[p] = 9'(y); bus.player_dir[p] = 2'(d);
    endtask

    task automatic pulse_carry(input logic [NP-1:0] m);
        bus.carry = m;
        tick();
        bus.carry = 2'b00;
    endtask

    initial begin
        reset = 1'b0;
        bus.enable = 1'b0; bus.num_players = 2'd2; bus.carry = 2'b00; bus.chop = 2'b00;
        bus.player_dir = '0; bus.player_x = '0; bus.player_y = '0;
        bus.ext_we = 1'b0; bus.ext_row = 3'd0; bus.ext_col = 4'd0; bus.ext_obj = 4'd0;
        repeat (2) tick();
        chk("reset grant", 512'(bus.grant), 512'(2'b00));
        chk("reset grid", 512'(bus.object_grid), 512'(0));
        reset = 1'b1; bus.enable = 1'b1;

        // pickup then drop on the same tile
        ext_write(6, 8, 3);
        place(0, 300, 208, 0);
        pulse_carry(2'b01); tick();
        chk("pickup grant", 512'(bus.grant), 512'(2'b01));
        chk("pickup held", 512'(bus.held_obj[0]), 512'(4'd3));
        chk("pickup cell", 512'(bus.object_grid[6][8]), 512'(4'd0));
        pulse_carry(2'b01); tick();
        chk("drop cell", 512'(bus.object_grid[6][8]), 512'(4'd3));
        chk("drop held", 512'(bus.held_obj[0]), 512'(4'd0));

        // blocked drop onto an occupied cell
        ext_write(6, 8, 5);
        pulse_carry(2'b01); tick();
        ext_write(6, 8, 2);
        pulse_carry(2'b01); tick();
        chk("blocked grant", 512'(bus.grant), 512'(2'b01));
        chk("blocked held", 512'(bus.held_obj[0]), 512'(4'd5));
        chk("blocked cell", 512'(bus.object_grid[6][8]), 512'(4'd2));

        // full chop by P1 on (3,4)
        place(1, 100, 100, 1);
        ext_write(3, 4, 2);
        bus.chop[1] = 1'b1;
        for (int i = 1; i <= CF; i++) begin
            tick();
            chk("chop count", 512'(bus.chop_progress[1]), 512'(i));
        end
        tick();
        chk("chop cell", 512'(bus.object_grid[3][4]), 512'(4'hA));
        chk("chop cleared", 512'(bus.chop_progress[1]), 512'(3'd0));
        bus.chop[1] = 1'b0;

        // chop released at count 3
        ext_write(3, 4, 2);
        bus.chop[1] = 1'b1;
        repeat (3) tick();
        chk("early count", 512'(bus.chop_progress[1]), 512'(3'd3));
        bus.chop[1] = 1'b0;
        tick();
        chk("early cleared", 512'(bus.chop_progress[1]), 512'(3'd0));
        tick();
        chk("early cell", 512'(bus.object_grid[3][4]), 512'(4'd2));

        // same-tile contention: P0 drops 5, then P1 picks it up
        ext_write(6, 8, 0);
        place(1, 300, 208, 0);
        pulse_carry(2'b11); tick();
        chk("cont grant0", 512'(bus.grant), 512'(2'b01));
        chk("cont cell", 512'(bus.object_grid[6][8]), 512'(4'd5));
        tick();
        chk("cont grant1", 512'(bus.grant), 512'(2'b10));
        chk("cont held1", 512'(bus.held_obj[1]), 512'(4'd5));

        // contention with an external write stalling the first grant edge
        bus.carry = 2'b11;
        tick();
        bus.carry = 2'b00;
        ext_write(0, 0, 1);
        chk("stall grant", 512'(bus.grant), 512'(2'b00));
        tick();
        chk("stall grant0", 512'(bus.grant), 512'(2'b01));
        tick();
        chk("stall grant1", 512'(bus.grant), 512'(2'b10));
        chk("stall cell", 512'(bus.object_grid[6][8]), 512'(4'd5));

        // P0 at column 0 facing left: no target
        place(0, 10, 208, 0);
        pulse_carry(2'b01);
        tick();
        chk("edge grant", 512'(bus.grant), 512'(2'b00));

        // single active player: P1 ignored
        bus.num_players = 2'd1;
        pulse_carry(2'b10); tick();
        chk("masked grant", 512'(bus.grant), 512'(2'b00));
        chk("masked held", 512'(bus.held_obj[1]), 512'(4'd0));
        bus.num_players = 2'd2;

        // enable dropped mid-chop
        place(1, 100, 100, 1);
        bus.chop[1] = 1'b1;
        repeat (2) tick();
        chk("en count", 512'(bus.chop_progress[1]), 512'(3'd2));
        bus.enable = 1'b0;
        tick();
        chk("en cleared", 512'(bus.chop_progress[1]), 512'(3'd0));
        bus.enable = 1'b1; bus.chop[1] = 1'b0;
        tick();

        // reset mid-operation with held object and a pending carry
        place(1, 300, 208, 0);
        pulse_carry(2'b10); tick();
        chk("pre-reset held1", 512'(bus.held_obj[1]), 512'(4'd5));
        place(0, 300, 208, 0);
        pulse_carry(2'b01);
        #2 reset = 1'b0;
        #1;
        chk("async grid", 512'(bus.object_grid), 512'(0));
        chk("async held", 512'(bus.held_obj), 512'(0));
        chk("async grant", 512'(bus.grant), 512'(2'b00));
        #1 reset = 1'b1;
        repeat (3) begin
            tick();
            chk("post-reset grant", 512'(bus.grant), 512'(2'b00));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
